// File: rtl/clm_inversion_sequencer_pkg.sv
// Shared types and helpers for the CLM inversion sequencer.
// A state_t word is {data[7:0], red[D-1:0]}; data = x ^ mask(red, B).
package clm_inversion_sequencer_pkg;

   localparam int unsigned D = 4;
   localparam int unsigned W = 8 + D;

   typedef logic [W-1:0]      state_t;
   typedef logic [D-1:0]      red_poly_t;
   typedef logic [D-1:0][7:0] nm_matrix_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } seq_state_t;

   // Index of the highest set bit; 0 for an all-zero input.
   function automatic logic [2:0] msb_index(input logic [7:0] e);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++)
         if (e[i]) idx = 3'(i);
      return idx;
   endfunction

   // XOR of the encoder rows selected by the redundancy bits.
   function automatic logic [7:0] red_mask(input red_poly_t r,
                                           input nm_matrix_t b);
      logic [7:0] m;
      m = '0;
      for (int i = 0; i < int'(D); i++)
         if (r[i]) m = m ^ b[i];
      return m;
   endfunction

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                         input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
      end
      return p;
   endfunction

endpackage

// File: rtl/clm_inversion_sequencer_multiplier.sv
// Combinational CLM multiplier: out = encode(dec(p1)*dec(p2), r).
// Ports: p1, p2 operands; r refresh polynomial; B_ext encoder; out product.
module multiplier
   import clm_inversion_sequencer_pkg::*;
(
   input  state_t     p1,
   input  state_t     p2,
   input  red_poly_t  r,
   input  nm_matrix_t B_ext,
   output state_t     out
);

   logic [7:0] xa;
   logic [7:0] xb;
   logic [7:0] y;

   assign xa  = p1[W-1:D] ^ red_mask(p1[D-1:0], B_ext);
   assign xb  = p2[W-1:D] ^ red_mask(p2[D-1:0], B_ext);
   assign y   = gf_mul(xa, xb);

   // Fresh redundancy on every product; no old mask survives.
   assign out = {y ^ red_mask(r, B_ext), r};

endmodule

// File: rtl/clm_inversion_sequencer.sv
// Square-and-multiply sequencer computing masked x^EXP with one multiplier.
// Ports: in_* operand, rnd_* refresh words, out_* result, B_ext, busy.
module clm_inversion_sequencer
   import clm_inversion_sequencer_pkg::*;
#(
   parameter int unsigned d   = D,
   parameter logic [7:0]  EXP = 8'd254
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  state_t     in_data,
   input  logic       rnd_valid,
   output logic       rnd_ready,
   input  red_poly_t  rnd_data,
   input  nm_matrix_t B_ext,
   output logic       out_valid,
   input  logic       out_ready,
   output state_t     out_data,
   output logic       busy
);

   if (EXP == 8'd0) begin : g_bad_exp
      $error("EXP must be in 1..255");
   end

   if (d != D) begin : g_bad_d
      $error("d must match package D");
   end

   localparam logic [2:0] TOP = msb_index(EXP);

   seq_state_t state;
   state_t     acc;
   state_t     base;
   state_t     p2;
   state_t     mul_out;
   logic [2:0] bit_idx;
   logic       pending_mul;
   logic       accept;

   assign p2 = pending_mul ? base : acc;

   multiplier u_mul (
      .p1    (acc),
      .p2    (p2),
      .r     (rnd_data),
      .B_ext (B_ext),
      .out   (mul_out)
   );

   // in_ready follows out_ready in DONE so results and operands overlap.
   assign in_ready  = !rst && ((state == IDLE) ||
                               (state == DONE && out_ready));
   assign accept    = in_valid && in_ready;
   assign rnd_ready = (state == RUN) && rnd_valid;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         base        <= '0;
         bit_idx     <= '0;
         pending_mul <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (state == DONE && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
               if (accept) begin
                  base <= in_data;
                  acc  <= in_data;
                  if (TOP == 3'd0) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     out_data  <= in_data;
                  end else begin
                     bit_idx     <= TOP - 3'd1;
                     pending_mul <= 1'b0;
                     state       <= RUN;
                  end
               end
            end
            RUN: begin
               if (rnd_valid) begin
                  acc <= mul_out;
                  if (!pending_mul && EXP[bit_idx]) begin
                     pending_mul <= 1'b1;
                  end else begin
                     pending_mul <= 1'b0;
                     if (bit_idx == 3'd0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= mul_out;
                     end else begin
                        bit_idx <= bit_idx - 3'd1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clm_inversion_sequencer.sv
// Directed bench for clm_inversion_sequencer (EXP=254, 1, 3 builds).
// Ports: drives all DUT inputs, checks decoded results and timing.
module tb_clm_inversion_sequencer;
   import clm_inversion_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nm_matrix_t b_ext;
   logic      in_valid  [3];
   logic      in_ready  [3];
   state_t    in_data   [3];
   logic      rnd_valid [3];
   logic      rnd_ready [3];
   red_poly_t rnd_data  [3];
   logic      out_valid [3];
   logic      out_ready [3];
   state_t    out_data  [3];
   logic      busy      [3];
   int        pulses    [3] = '{0, 0, 0};

   int compared   = 0;
   int mismatched = 0;

   clm_inversion_sequencer #(.d(4), .EXP(8'd254)) u_inv (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .rnd_valid(rnd_valid[0]), .rnd_ready(rnd_ready[0]),
      .rnd_data(rnd_data[0]), .B_ext(b_ext),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_data(out_data[0]), .busy(busy[0])
   );

   clm_inversion_sequencer #(.d(4), .EXP(8'd1)) u_e1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .rnd_valid(rnd_valid[1]), .rnd_ready(rnd_ready[1]),
      .rnd_data(rnd_data[1]), .B_ext(b_ext),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_data(out_data[1]), .busy(busy[1])
   );

   clm_inversion_sequencer #(.d(4), .EXP(8'd3)) u_e3 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
      .rnd_valid(rnd_valid[2]), .rnd_ready(rnd_ready[2]),
      .rnd_data(rnd_data[2]), .B_ext(b_ext),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_data(out_data[2]), .busy(busy[2])
   );

   always @(posedge clk)
      for (int k = 0; k < 3; k++)
         if (rnd_valid[k] && rnd_ready[k]) pulses[k] <= pulses[k] + 1;

   function automatic logic [7:0] msk(input red_poly_t r);
      logic [7:0] m;
      m = '0;
      for (int i = 0; i < 4; i++)
         if (r[i]) m = m ^ b_ext[i];
      return m;
   endfunction

   function automatic state_t enc(input logic [7:0] x, input red_poly_t r);
      return {x ^ msk(r), r};
   endfunction

   function automatic logic [7:0] dec(input state_t c);
      return c[11:4] ^ msk(c[3:0]);
   endfunction

   // Reference field arithmetic: full carry-less product, then reduce.
   function automatic logic [7:0] ref_mul(input logic [7:0] a,
                                          input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (15'(a) << i);
      for (int i = 14; i >= 8; i--)
         if (p[i]) p = p ^ (15'h11B << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] ref_inv(input logic [7:0] x);
      for (int y = 1; y < 256; y++)
         if (ref_mul(x, 8'(y)) == 8'h01) return 8'(y);
      return 8'h00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] want);
      compared++;
      assert (obs === want) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   // One full operation on instance k; stalls bit c drops rnd_valid in
   // cycle c after the accept.
   task automatic run_op(input int k, input logic [7:0] x,
                         input logic [31:0] stalls,
                         output logic [7:0] y, output int lat,
                         output int np);
      int  p0;
      bit  seen;
      @(negedge clk);
      rnd_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
      in_valid[k]  = 1'b1;
      in_data[k]   = enc(x, 4'($urandom));
      #1;
      chk("accept_ready", 32'(in_ready[k]), 32'd1);
      p0   = pulses[k];
      lat  = 0;
      seen = 1'b0;
      for (int c = 1; c <= 64 && !seen; c++) begin
         @(negedge clk);
         in_valid[k] = 1'b0;
         if (out_valid[k]) begin
            seen = 1'b1;
            lat  = c;
            rnd_valid[k] = 1'b0;
         end else begin
            rnd_valid[k] = (c < 32) ? !stalls[c] : 1'b1;
            rnd_data[k]  = 4'($urandom);
         end
      end
      chk("result_seen", 32'(seen), 32'd1);
      np = pulses[k] - p0;
      y  = dec(out_data[k]);
      out_ready[k] = 1'b1;
      @(negedge clk);
      out_ready[k] = 1'b0;
      chk("valid_drop", 32'(out_valid[k]), 32'd0);
      chk("idle_busy", 32'(busy[k]), 32'd0);
   endtask

   task automatic wait_out(input int k, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (out_valid[k]) begin
            seen = 1'b1;
         end else begin
            @(negedge clk);
            rnd_data[k] = 4'($urandom);
         end
      end
      chk("wait_out", 32'(seen), 32'd1);
   endtask

   initial begin
      logic [7:0] y;
      logic [7:0] xr;
      int         lat;
      int         np;
      bit         seen;
      state_t     first;

      b_ext = {8'hA5, 8'h3C, 8'h0F, 8'hD2};
      rst   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid[k]  = 1'b0;
         in_data[k]   = '0;
         rnd_valid[k] = 1'b0;
         rnd_data[k]  = '0;
         out_ready[k] = 1'b0;
      end

      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
      chk("rst_busy", 32'(busy[0]), 32'd0);
      chk("rst_in_ready", 32'(in_ready[0]), 32'd0);
      chk("rst_out_data", 32'(out_data[0]), 32'd0);
      rst = 1'b0;
      #1;
      chk("idle_in_ready", 32'(in_ready[0]), 32'd1);

      run_op(0, 8'h02, 32'd0, y, lat, np);
      chk("inv02", 32'(y), 32'h8D);
      chk("inv02_lat", 32'(lat), 32'd14);
      chk("inv02_rnd", 32'(np), 32'd13);

      run_op(0, 8'h53, 32'd0, y, lat, np);
      chk("inv53", 32'(y), 32'hCA);

      run_op(0, 8'h00, 32'd0, y, lat, np);
      chk("inv00", 32'(y), 32'h00);
      run_op(0, 8'h01, 32'd0, y, lat, np);
      chk("inv01", 32'(y), 32'h01);

      run_op(0, 8'h02, (32'd1 << 3) | (32'd1 << 4) | (32'd1 << 9),
             y, lat, np);
      chk("stall_inv02", 32'(y), 32'h8D);
      chk("stall_lat", 32'(lat), 32'd17);
      chk("stall_rnd", 32'(np), 32'd13);

      for (int i = 0; i < 3; i++) begin
         xr = 8'($urandom_range(2, 255));
         run_op(0, xr, 32'd0, y, lat, np);
         chk("model_inv", 32'(y), 32'(ref_inv(xr)));
      end

      // Back-to-back with output backpressure.
      @(negedge clk);
      rnd_valid[0] = 1'b1;
      rnd_data[0]  = 4'($urandom);
      out_ready[0] = 1'b0;
      in_valid[0]  = 1'b1;
      in_data[0]   = enc(8'h02, 4'($urandom));
      @(negedge clk);
      in_data[0]   = enc(8'h53, 4'($urandom));
      rnd_data[0]  = 4'($urandom);
      wait_out(0, seen);
      first = out_data[0];
      chk("b2b_first", 32'(dec(first)), 32'h8D);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("b2b_hold", 32'(out_data[0]), 32'(first));
         chk("b2b_no_accept", 32'(in_ready[0]), 32'd0);
      end
      out_ready[0] = 1'b1;
      #1;
      chk("b2b_ready_follow", 32'(in_ready[0]), 32'd1);
      @(negedge clk);
      chk("b2b_second_run", 32'(busy[0] && !out_valid[0]), 32'd1);
      in_data[0] = enc(8'hFF, 4'($urandom));
      wait_out(0, seen);
      chk("b2b_second", 32'(dec(out_data[0])), 32'hCA);
      @(negedge clk);
      in_valid[0] = 1'b0;
      chk("b2b_third_run", 32'(busy[0] && !out_valid[0]), 32'd1);
      wait_out(0, seen);
      chk("b2b_third", 32'(dec(out_data[0])), 32'h1C);
      @(negedge clk);
      chk("b2b_drained", 32'(busy[0] || out_valid[0]), 32'd0);
      out_ready[0] = 1'b0;
      rnd_valid[0] = 1'b0;

      // Reset in the middle of an operation.
      @(negedge clk);
      rnd_valid[0] = 1'b1;
      in_valid[0]  = 1'b1;
      in_data[0]   = enc(8'h02, 4'($urandom));
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (5) begin
         @(negedge clk);
         rnd_data[0] = 4'($urandom);
      end
      chk("mid_busy", 32'(busy[0]), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid[0]), 32'd0);
      chk("mid_rst_busy", 32'(busy[0]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rnd_valid[0] = 1'b0;
      run_op(0, 8'h03, 32'd0, y, lat, np);
      chk("inv03_after_rst", 32'(y), 32'hF6);
      chk("inv03_lat", 32'(lat), 32'd14);

      run_op(1, 8'h57, 32'd0, y, lat, np);
      chk("e1_val", 32'(y), 32'h57);
      chk("e1_lat", 32'(lat), 32'd1);
      chk("e1_rnd", 32'(np), 32'd0);

      run_op(2, 8'h02, 32'd0, y, lat, np);
      chk("e3_val", 32'(y), 32'h08);
      chk("e3_lat", 32'(lat), 32'd3);
      chk("e3_rnd", 32'(np), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/clm_inversion_sequencer.md
Name: clm_inversion_sequencer

Overview:
- Sequences one instance of the combinational CLM multiplier (module multiplier) to compute x^EXP by left-to-right square-and-multiply. The default EXP=254 gives the masked GF(2^8) inversion used by the S-box.
- Sits between the masked-state pipeline and the S-box affine stage.
- Handles per-multiplication refresh randomness through a valid/ready port, and valid/ready for operands and results.

Parameters:
- d, 4, number of redundancy bits; state_t width is 8+d and red_poly_t width is d.
- EXP, 254, 8-bit exponent; legal range 1..255; elaboration assertion fails for 0.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand offered
- in_ready  output  1  operand accepted when in_valid&in_ready
- in_data  input  8+d  masked operand x (state_t)
- rnd_valid  input  1  fresh refresh polynomial available
- rnd_ready  output  1  rnd_data consumed this cycle
- rnd_data  input  d  refresh polynomial r (red_poly_t)
- B_ext  input  nm_matrix_t  systematic encoder; quasi-static, must not change while busy
- out_valid  output  1  result valid
- out_ready  input  1  result accepted when out_valid&out_ready
- out_data  output  8+d  masked x^EXP (state_t)
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous) forces: state=IDLE, acc=0, base=0, bit_idx=0, pending_mul=0, out_valid=0, out_data=0, rnd_ready=0, busy=0, in_ready=0 during reset and 1 in the first cycle after reset (IDLE).
- Registers:
  - base: latched operand.
  - acc: accumulator, state_t.
  - bit_idx: 3-bit exponent bit index.
  - pending_mul: flag, multiply still owed for the current bit.
  - top: constant index of the highest set bit of EXP, computed at elaboration.
- States:
  - IDLE: in_ready=1. On accept: base<=in_data, acc<=in_data. If top==0, go to DONE with out_data<=in_data. Otherwise bit_idx<=top-1, pending_mul<=0, go to RUN.
  - RUN: each cycle issues exactly one multiplication, and only when rnd_valid=1. rnd_ready = rnd_valid while in RUN.
    - Operands: p1=acc; p2=acc if pending_mul=0 (square), p2=base if pending_mul=1 (multiply); r=rnd_data; B_ext passed through.
    - On an issued cycle: acc<=multiplier out.
    - After a square: if EXP[bit_idx]=1, set pending_mul<=1; else advance.
    - After a multiply: clear pending_mul and advance.
    - Advance: if bit_idx==0, go to DONE and out_data<=new acc; else bit_idx<=bit_idx-1.
    - rnd_valid=0: stall. No register changes and rnd_ready=0; the multiplier output is ignored.
  - DONE: out_valid=1, out_data held stable until accepted.
    - On out_ready: out_valid<=0.
    - in_ready=out_ready in DONE, so results and operands can go back-to-back. A simultaneous input accept goes straight to RUN (or DONE if top==0) with the new operand; otherwise go to IDLE.
- Operation count: popcount(EXP)-1 multiplies plus top squares. EXP=254 needs 13 operations.
- Latency: accept to out_valid is 13+1 cycles at full randomness. Each stall cycle adds 1.
- Randomness: exactly one rnd_data word per issued operation. No word is consumed outside RUN, and no word is reused.
- Reset mid-operation: the computation is abandoned with no output.
- Inputs arriving while busy are not accepted; in_ready=0 outside IDLE and DONE.
- Zero operand: the codeword of 0 yields the codeword of 0 (0^254=0). No special casing.

Decomposition:
- In package types: add a sequencer state enum (IDLE, RUN, DONE), plus a constant function msb_index(EXP) used to derive top. state_t, red_poly_t and nm_matrix_t are already there.
- One sub-module instance: multiplier (existing). Everything else stays in this module.
- The bench carries a golden model with encode/decode using B_ext and GF(2^8) inversion modulo 0x11B.

Test Plan:
- Basic: encode(0x02), rnd_valid tied 1 -> out_valid exactly 14 cycles after accept, decode(out_data)=0x8D, 13 rnd_ready pulses.
- Basic: encode(0x53) -> decode(out_data)=0xCA.
- Edge operands: encode(0x00) -> 0x00 and encode(0x01) -> 0x01, each with random r; the codeword check passes.
- Randomness stalls: 0x02 with rnd_valid low on cycles 3, 4 and 9 -> out_valid after 17 cycles, result 0x8D, still exactly 13 rnd_ready pulses.
- Back-to-back with output backpressure: inputs 0x02, 0x53, 0xFF in sequence; out_ready low for 5 cycles on the first result -> out_data holds stable, the second operand is accepted in the cycle out_ready rises, results in order 0x8D, 0xCA, 0x1C.
- Reset and parameters:
  - rst asserted at op 6 of an operation -> out_valid=0 and busy=0 immediately; the next operand 0x03 yields 0xF6.
  - EXP=1 build: 0x57 -> 0x57 after 1 cycle with 0 rnd_ready pulses.
  - EXP=3 build: 0x02 -> 0x08 with 2 operations.
